// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped, read-only data cache.
// Looks up the external tag array against internal valid bits. On a miss it
// fetches the 4-word block from main memory into the data array, then
// updates the tag. Completion is a one-cycle ready pulse. Hit and miss
// counters saturate at all-ones.
module cache_controller #(
  parameter int WORD     = 32,
  parameter int ADDRESSL = 15,
  parameter int OFFSETL  = 2,
  parameter int INDEXL   = 8,
  parameter int TAGL     = ADDRESSL - INDEXL - OFFSETL
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req,
  input  logic [ADDRESSL-1:0]         address,
  output logic                        ready,
  output logic [ADDRESSL-1:0]         numOfHits,
  output logic [ADDRESSL-1:0]         numOfMisses,
  output logic [INDEXL-1:0]           tagIndex,
  input  logic [TAGL-1:0]             tagRdData,
  output logic                        tagWrEn,
  output logic [TAGL-1:0]             tagWrData,
  output logic [INDEXL+OFFSETL-1:0]   dataAddr,
  output logic                        dataWrEn,
  output logic [WORD-1:0]             dataWrData,
  output logic                        memRead,
  output logic [ADDRESSL-1:0]         memAddress,
  input  logic [WORD-1:0]             memData,
  input  logic                        memAck
);

  localparam int LINES = 1 << INDEXL;

  typedef struct packed {
    logic [TAGL-1:0]    tag;
    logic [INDEXL-1:0]  idx;
    logic [OFFSETL-1:0] off;
  } addr_t;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, UPDATE, DONE} state_t;

  state_t             state;
  addr_t              a;
  logic [LINES-1:0]   valid;
  logic [OFFSETL-1:0] w;
  logic               hit;

  assign hit        = valid[a.idx] && (tagRdData == a.tag);
  assign tagIndex   = a.idx;
  assign tagWrData  = a.tag;
  assign memAddress = {a.tag, a.idx, w};
  // A write lands only on an ack while filling; stray acks elsewhere are inert.
  assign dataWrEn   = (state == FILL) && memAck;
  assign dataWrData = memData;
  assign dataAddr   = dataWrEn ? {a.idx, w} : {a.idx, a.off};

  // Request sequencing, fill counting, valid bits and hit/miss counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      valid       <= '0;
      w           <= '0;
      ready       <= 1'b0;
      tagWrEn     <= 1'b0;
      memRead     <= 1'b0;
      numOfHits   <= '0;
      numOfMisses <= '0;
    end else begin
      ready   <= 1'b0;
      tagWrEn <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            a     <= address;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (numOfHits != '1) numOfHits <= numOfHits + 1'b1;
            ready <= 1'b1;
            state <= DONE;
          end else begin
            if (numOfMisses != '1) numOfMisses <= numOfMisses + 1'b1;
            w       <= '0;
            memRead <= 1'b1;
            state   <= FILL;
          end
        end
        FILL: begin
          if (memAck) begin
            w <= w + 1'b1;
            if (w == {OFFSETL{1'b1}}) begin
              memRead <= 1'b0;
              tagWrEn <= 1'b1;
              state   <= UPDATE;
            end
          end
        end
        UPDATE: begin
          valid[a.idx] <= 1'b1;
          ready        <= 1'b1;
          state        <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: models the external tag and data
// arrays plus a main memory with programmable ack latency.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [14:0] address;
  logic        ready;
  logic [14:0] numOfHits, numOfMisses;
  logic [7:0]  tagIndex;
  logic [4:0]  tagRdData;
  logic        tagWrEn;
  logic [4:0]  tagWrData;
  logic [9:0]  dataAddr;
  logic        dataWrEn;
  logic [31:0] dataWrData;
  logic        memRead;
  logic [14:0] memAddress;
  logic [31:0] memData;
  logic        memAck;

  int compared = 0;
  int mismatched = 0;
  int memlat = 2;
  logic force_ack = 1'b0;
  int timeouts = 0;

  logic [4:0]  tagmem  [256];
  logic [31:0] datamem [1024];
  logic [14:0] acklog  [64];
  logic [9:0]  wrlog   [64];
  logic [4:0]  last_tw;
  int ack_cnt = 0, wr_cnt = 0, tw_cnt = 0, rdy_cnt = 0, mr_cnt = 0;

  cache_controller dut (
    .clk(clk), .rst(rst), .req(req), .address(address), .ready(ready),
    .numOfHits(numOfHits), .numOfMisses(numOfMisses), .tagIndex(tagIndex),
    .tagRdData(tagRdData), .tagWrEn(tagWrEn), .tagWrData(tagWrData),
    .dataAddr(dataAddr), .dataWrEn(dataWrEn), .dataWrData(dataWrData),
    .memRead(memRead), .memAddress(memAddress), .memData(memData), .memAck(memAck)
  );

  always #5 clk = ~clk;

  assign tagRdData = tagmem[tagIndex];

  function automatic logic [31:0] pat(input logic [14:0] a);
    return 32'hC0DE0000 | {17'd0, a};
  endfunction

  // Array models and event counters.
  always @(posedge clk) begin
    if (memAck && memRead) begin
      acklog[ack_cnt[5:0]] <= memAddress;
      ack_cnt <= ack_cnt + 1;
    end
    if (dataWrEn) begin
      datamem[dataAddr] <= dataWrData;
      wrlog[wr_cnt[5:0]] <= dataAddr;
      wr_cnt <= wr_cnt + 1;
    end
    if (tagWrEn) begin
      tagmem[tagIndex] <= tagWrData;
      last_tw <= tagWrData;
      tw_cnt <= tw_cnt + 1;
    end
    if (ready)   rdy_cnt <= rdy_cnt + 1;
    if (memRead) mr_cnt  <= mr_cnt + 1;
  end

  // Main memory: acks each word memlat cycles after it is requested.
  initial begin
    int cnt;
    cnt = 0;
    memAck = 1'b0;
    memData = '0;
    forever begin
      @(negedge clk);
      memAck = 1'b0;
      if (force_ack) begin
        memAck = 1'b1;
        memData = 32'hDEADBEEF;
      end else if (memRead) begin
        if (cnt >= memlat) begin
          memAck = 1'b1;
          memData = pat(memAddress);
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request, return cycles from sampling edge to ready; ends in IDLE.
  task automatic access(input logic [14:0] a, output int lat);
    @(negedge clk);
    req = 1'b1;
    address = a;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ready) timeouts++;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, a0, w0, r0, t0, m0, n;
    rst = 1'b1;
    req = 1'b0;
    address = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   32'(ready), 0);
    chk("rst_memRead", 32'(memRead), 0);
    chk("rst_tagWrEn", 32'(tagWrEn), 0);
    chk("rst_hits",    32'(numOfHits), 0);
    chk("rst_misses",  32'(numOfMisses), 0);
    chk("rst_dataAddr", 32'(dataAddr), 0);
    @(negedge clk); rst = 1'b0;

    // Cold miss at 1024, 2-cycle memory
    memlat = 2;
    a0 = ack_cnt; w0 = wr_cnt; r0 = rdy_cnt; t0 = tw_cnt;
    access(15'd1024, lat);
    chk("miss_lat", 32'(lat), 15);
    chk("miss_acks", 32'(ack_cnt - a0), 4);
    for (int i = 0; i < 4; i++) begin
      chk("miss_memaddr", 32'(acklog[6'((a0 + i) % 64)]), 32'(1024 + i));
      chk("miss_wraddr",  32'(wrlog[6'((w0 + i) % 64)]), 32'(i));
    end
    chk("miss_wrs", 32'(wr_cnt - w0), 4);
    chk("miss_tagwr", 32'(tw_cnt - t0), 1);
    chk("miss_tagdata", 32'(last_tw), 1);
    chk("miss_ready", 32'(rdy_cnt - r0), 1);
    chk("miss_misses", 32'(numOfMisses), 1);
    chk("miss_hits", 32'(numOfHits), 0);
    chk("miss_data", datamem[dataAddr], pat(15'd1024));

    // Hit at 1027
    m0 = mr_cnt; r0 = rdy_cnt;
    access(15'd1027, lat);
    chk("hit_lat", 32'(lat), 2);
    chk("hit_noread", 32'(mr_cnt - m0), 0);
    chk("hit_dataAddr", 32'(dataAddr), 3);
    chk("hit_hits", 32'(numOfHits), 1);
    chk("hit_ready", 32'(rdy_cnt - r0), 1);
    chk("hit_data", datamem[dataAddr], pat(15'd1027));

    // Tag conflict on index 0, zero-wait memory
    memlat = 0;
    access(15'd2048, lat);
    chk("conf_lat", 32'(lat), 7);
    chk("conf_tag", 32'(last_tw), 2);
    chk("conf_data", datamem[dataAddr], pat(15'd2048));
    access(15'd1024, lat);
    chk("conf_remiss_lat", 32'(lat), 7);
    chk("conf_misses", 32'(numOfMisses), 3);
    chk("conf_hits", 32'(numOfHits), 1);

    // Sequential sweep from a clean cache
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    r0 = rdy_cnt; timeouts = 0;
    for (int a = 1024; a <= 9215; a++) access(15'(a), lat);
    chk("sweep_misses", 32'(numOfMisses), 2048);
    chk("sweep_hits", 32'(numOfHits), 6144);
    chk("sweep_ready", 32'(rdy_cnt - r0), 8192);
    chk("sweep_timeouts", 32'(timeouts), 0);

    // Reset in the middle of a fill
    memlat = 2;
    a0 = ack_cnt; r0 = rdy_cnt;
    @(negedge clk); req = 1'b1; address = 15'd1024;
    @(posedge clk); #1; req = 1'b0;
    n = 0;
    while ((ack_cnt - a0) < 2 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("rstfill_acks", 32'(ack_cnt - a0), 2);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rstfill_memRead", 32'(memRead), 0);
    chk("rstfill_hits", 32'(numOfHits), 0);
    chk("rstfill_misses", 32'(numOfMisses), 0);
    @(negedge clk); rst = 1'b0;
    w0 = wr_cnt;
    @(posedge clk); #1; force_ack = 1'b1;
    @(posedge clk); #1; force_ack = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("late_ack_wr", 32'(wr_cnt - w0), 0);
    chk("late_ack_memRead", 32'(memRead), 0);
    chk("late_ack_ready", 32'(rdy_cnt - r0), 0);
    access(15'd1024, lat);
    chk("rerq_misses", 32'(numOfMisses), 1);
    chk("rerq_hits", 32'(numOfHits), 0);

    // req toggling during LOOKUP/FILL, stray ack in IDLE
    w0 = wr_cnt; r0 = rdy_cnt; a0 = ack_cnt;
    force_ack = 1'b1;
    @(posedge clk); #1; force_ack = 1'b0;
    @(posedge clk); #1;
    chk("idle_ack_wr", 32'(wr_cnt - w0), 0);
    chk("idle_ack_ready", 32'(rdy_cnt - r0), 0);
    @(negedge clk); req = 1'b1; address = 15'd3072;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req = ~req;
      address = 15'(i);
    end
    repeat (30) @(posedge clk); #1;
    chk("tog_ready", 32'(rdy_cnt - r0), 1);
    chk("tog_wr", 32'(wr_cnt - w0), 4);
    chk("tog_lastaddr", 32'(acklog[6'((a0 + 3) % 64)]), 3075);
    chk("tog_misses", 32'(numOfMisses), 2);
    chk("tog_hits", 32'(numOfHits), 0);
    chk("tog_data", datamem[dataAddr], pat(15'd3072));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM for the direct-mapped data cache: 1024-word data array, 4-word blocks, 256 lines, 15-bit word address into 32K-word main memory.
- Accepts one request at a time and checks the external tag array against its own valid bits.
- On a miss it fetches the 4-word block from main memory, writes it into the data array and updates the tag.
- Signals completion with a one-cycle ready pulse and keeps hit and miss counters.

Parameters:
- WORD, 32, data width in bits
- ADDRESSL, 15, word-address width
- OFFSETL, 2, word-in-block bits (4-word blocks)
- INDEXL, 8, line-index bits (256 lines)
- TAGL, ADDRESSL-INDEXL-OFFSETL = 5, tag width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  request; sampled only in IDLE
- address  in  ADDRESSL  requested word address {tag,index,offset}
- ready  out  1  one-cycle pulse; read data valid at data array output
- numOfHits  out  ADDRESSL  hit counter
- numOfMisses  out  ADDRESSL  miss counter
- tagIndex  out  INDEXL  tag-array read/write index
- tagRdData  in  TAGL  tag-array combinational read data
- tagWrEn  out  1  tag-array write strobe
- tagWrData  out  TAGL  tag to write
- dataAddr  out  INDEXL+OFFSETL  data-array address (read and write)
- dataWrEn  out  1  data-array write strobe
- dataWrData  out  WORD  data-array write data
- memRead  out  1  main-memory read request; held until memAck
- memAddress  out  ADDRESSL  main-memory word address
- memData  in  WORD  main-memory read data; valid with memAck
- memAck  in  1  one-cycle acknowledge per word

Behaviour:
- Reset (synchronous, high), valid from any state, including mid-fill:
  - State goes to IDLE; all 256 valid bits cleared; word counter cleared.
  - ready, tagWrEn, dataWrEn and memRead go to 0.
  - numOfHits and numOfMisses go to 0; latched address goes to 0.
  - A memAck arriving after reset is ignored.
- Internal registers: latched address A; A.tag = A[14:10], A.index = A[9:2], A.offset = A[1:0].
- tagIndex = A.index in all states.
- IDLE:
  - req=1 latches address into A; next state LOOKUP.
  - req=0 stays in IDLE.
  - req is ignored in every other state.
- LOOKUP (1 cycle):
  - Hit = valid[A.index] and tagRdData == A.tag.
  - Hit: increment numOfHits; next state DONE.
  - Miss: increment numOfMisses; word counter w = 0; next state FILL.
- FILL:
  - memRead = 1; memAddress = {A.tag, A.index, w}.
  - In the cycle memAck = 1: dataWrEn = 1, dataAddr = {A.index, w}, dataWrData = memData; w increments.
  - After the ack with w = 3: next state UPDATE. memRead is low in the cycle after the 4th ack.
  - memRead stays high between acks; memory latency is unbounded.
  - memAck outside FILL has no effect.
- UPDATE (1 cycle): tagWrEn = 1, tagWrData = A.tag; valid[A.index] set to 1; next state DONE.
- DONE (1 cycle): ready = 1; dataAddr = {A.index, A.offset}; next state IDLE.
- dataAddr = {A.index, A.offset} in every state except FILL ack cycles.
- Latency (req sampled at edge 0):
  - Hit: ready high in cycle 2.
  - Miss: ready high 2 cycles after the 4th memAck cycle.
  - Minimum miss latency, with zero-wait acks: 7 cycles.
- Back-to-back requests: a req held high across DONE is re-sampled in the following IDLE cycle, so the minimum request period is 3 cycles.
- Counters saturate at all-ones; no wrap.
- A line is overwritten on a tag conflict; there is no write-back (read-only cache).

Test Plan:
- Reset, then req with address 1024, memory acking 2 cycles after memRead -> memAddress sequence 1024, 1025, 1026, 1027; 4 dataWrEn pulses at dataAddr 0..3; tagWrEn with tagWrData = 1; ready once; numOfMisses = 1, numOfHits = 0.
- Then req with address 1027 -> ready exactly 2 cycles after sampling; no memRead; dataAddr = 3; numOfHits = 1.
- Then address 2048 (same index 0, tag 2) -> miss and refill; then address 1024 -> miss again. Final counts: numOfMisses = 3, numOfHits = 1.
- Sequential sweep over addresses 1024..9215, req re-issued on each ready -> numOfMisses = 2048, numOfHits = 6144; no access overlaps another.
- Assert rst during FILL after 2 acks -> next cycle state IDLE with memRead = 0 and counters = 0; a late memAck causes no dataWrEn. Re-request address 1024 -> miss, because valid bits were cleared.
- Toggle req during LOOKUP and FILL, and pulse memAck while in IDLE -> no extra writes, no state change, exactly one ready per sampled request.
